// File: rtl/phase_scan_pkg.sv
// ---------------------------------------------------------------------------
// phase_scan_pkg
// Shared types and constants for the phase scan controller.
//   scan_state_e : FSM states of phase_scan_ctrl
//   PERIOD_W     : width of the measured period / period counter
//   PERIOD_MAX   : saturation value of the period counter
// ---------------------------------------------------------------------------
package phase_scan_pkg;

    localparam int PERIOD_W = 32;
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETTLE,
        ST_ARM,
        ST_MEAS,
        ST_OUT
    } scan_state_e;

endpackage

// File: rtl/phase_edge_sync.sv
// ---------------------------------------------------------------------------
// phase_edge_sync
// One channel of phase-pulse conditioning: a 2-FF synchronizer followed by a
// one-cycle glitch filter (current synchronized sample OR previous sample).
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, clears all flops
//   async_i : asynchronous phase pulse input
//   filt_o  : synchronized, filtered level
// ---------------------------------------------------------------------------
module phase_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic filt_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two synchronizer stages plus one history stage for the glitch filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // A single-cycle low dropout is bridged by ORing with the previous sample.
    assign filt_o = sync_q | prev_q;

endmodule

// File: rtl/phase_scan_ctrl.sv
// ---------------------------------------------------------------------------
// phase_scan_ctrl
// Round-robin phase period scanner. Each enabled channel is selected in turn,
// allowed to settle, then the distance between two rising edges of its
// filtered phase input is measured and offered on a valid/ready result port.
// Optional macro PHASE_SCAN_AVG_EN: measure 4 consecutive periods and report
// their average (34-bit sum >> 2, saturated to 32 bits).
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   phase_in[NCH]      : asynchronous phase pulses, one per channel
//   chan_en[NCH]       : per-channel scan enable
//   run                : 1 = keep scanning, 0 = stop after next accepted result
//   res_ready          : consumer accepts the result
//   res_valid          : result available (held until accepted)
//   res_chan           : channel of the result
//   res_period         : measured period in clk cycles (0 on timeout)
//   res_timeout        : result is a timeout
//   busy               : FSM is outside IDLE
// ---------------------------------------------------------------------------
module phase_scan_ctrl
    import phase_scan_pkg::*;
#(
    parameter  int NCH         = 8,
    parameter  int SETTLE_CYC  = 4,
    parameter  int TIMEOUT_CYC = 1048576,
    localparam int CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      phase_in,
    input  logic [NCH-1:0]      chan_en,
    input  logic                run,
    input  logic                res_ready,
    output logic                res_valid,
    output logic [CW-1:0]       res_chan,
    output logic [PERIOD_W-1:0] res_period,
    output logic                res_timeout,
    output logic                busy
);

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] TO_LAST     = 32'(TIMEOUT_CYC - 1);
    localparam logic [CW:0] NCH_W       = (CW + 1)'(NCH);

    scan_state_e         state_q, state_d;
    logic [CW-1:0]       chan_q;
    logic                hist_q;
    logic [31:0]         settle_q;
    logic [31:0]         wait_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic [CW-1:0]       res_chan_q;
    logic [PERIOD_W-1:0] res_period_q;
    logic                res_timeout_q;

    logic [NCH-1:0]      filt;
    logic                selFilt;
    logic                edgeDet;
    logic                anyEn;
    logic [CW-1:0]       nextChan;
    logic [PERIOD_W-1:0] cntInc;
    logic                waitExp;
    logic                lastEdge;
    logic [PERIOD_W-1:0] measResult;

    // One conditioning slice per phase input.
    for (genvar g = 0; g < NCH; g++) begin : g_sync
        phase_edge_sync u_sync (
            .clk    (clk),
            .rst    (rst),
            .async_i(phase_in[g]),
            .filt_o (filt[g])
        );
    end

    // History follows the selected channel every cycle, so after a switch it
    // is reloaded from the new channel during SETTLE and no false edge appears.
    assign selFilt = filt[chan_q];
    assign edgeDet = selFilt & ~hist_q;
    assign anyEn   = |chan_en;
    assign cntInc  = (cnt_q == PERIOD_MAX) ? PERIOD_MAX : cnt_q + 1'b1;
    assign waitExp = (wait_q >= TO_LAST);

`ifdef PHASE_SCAN_AVG_EN
    logic [33:0] acc_q;
    logic [1:0]  edgeNum_q;
    logic [33:0] sumFull;
    logic [33:0] sumShift;

    // The final period is folded in combinationally at the fourth edge.
    assign sumFull    = acc_q + {2'b00, cntInc};
    assign sumShift   = sumFull >> 2;
    assign measResult = (sumShift[33:32] != 2'b00) ? PERIOD_MAX : sumShift[31:0];
    assign lastEdge   = (edgeNum_q == 2'd3);
`else
    assign measResult = cntInc;
    assign lastEdge   = 1'b1;
`endif

    // Round-robin pick: lowest enabled channel strictly after chan_q, wrapping;
    // the last candidate is chan_q itself so a lone channel is re-selected.
    always_comb begin
        logic [CW:0] cand;
        logic        found;
        nextChan = chan_q;
        found    = 1'b0;
        cand     = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = {1'b0, chan_q} + (CW + 1)'(i);
            if (cand >= NCH_W) cand = cand - NCH_W;
            if (!found && chan_en[cand[CW-1:0]]) begin
                nextChan = cand[CW-1:0];
                found    = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; in ARM/MEAS an edge is checked before the timeout so
    // an edge arriving on the expiry cycle still wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (run && anyEn) state_d = ST_SELECT;
            ST_SELECT: state_d = anyEn ? ST_SETTLE : ST_IDLE;
            ST_SETTLE: if (settle_q >= SETTLE_LAST) state_d = ST_ARM;
            ST_ARM:    if (edgeDet) state_d = ST_MEAS;
                       else if (waitExp) state_d = ST_OUT;
            ST_MEAS:   if (edgeDet) begin
                           if (lastEdge) state_d = ST_OUT;
                       end else if (waitExp) begin
                           state_d = ST_OUT;
                       end
            ST_OUT:    if (res_ready) state_d = run ? ST_SELECT : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        res_valid = (state_q == ST_OUT);
        busy      = (state_q != ST_IDLE);
    end

    assign res_chan    = res_chan_q;
    assign res_period  = res_period_q;
    assign res_timeout = res_timeout_q;

    // Datapath: channel pointer, counters, result registers. Result registers
    // are only written on the transition into OUT, so they hold while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            chan_q        <= CW'(NCH - 1);
            hist_q        <= 1'b0;
            settle_q      <= '0;
            wait_q        <= '0;
            cnt_q         <= '0;
            res_chan_q    <= '0;
            res_period_q  <= '0;
            res_timeout_q <= 1'b0;
`ifdef PHASE_SCAN_AVG_EN
            acc_q         <= '0;
            edgeNum_q     <= '0;
`endif
        end else begin
            hist_q <= selFilt;
            unique case (state_q)
                ST_SELECT: begin
                    if (anyEn) chan_q <= nextChan;
                    settle_q <= '0;
                    wait_q   <= '0;
                end
                ST_SETTLE: begin
                    settle_q <= settle_q + 1'b1;
                    wait_q   <= '0;
                end
                ST_ARM: begin
                    if (edgeDet) begin
                        cnt_q  <= '0;
                        wait_q <= '0;
`ifdef PHASE_SCAN_AVG_EN
                        acc_q     <= '0;
                        edgeNum_q <= '0;
`endif
                    end else if (waitExp) begin
                        res_chan_q    <= chan_q;
                        res_period_q  <= '0;
                        res_timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                ST_MEAS: begin
                    if (edgeDet) begin
                        wait_q <= '0;
                        if (lastEdge) begin
                            res_chan_q    <= chan_q;
                            res_period_q  <= measResult;
                            res_timeout_q <= 1'b0;
                        end
`ifdef PHASE_SCAN_AVG_EN
                        else begin
                            acc_q     <= acc_q + {2'b00, cntInc};
                            cnt_q     <= '0;
                            edgeNum_q <= edgeNum_q + 1'b1;
                        end
`endif
                    end else begin
                        cnt_q <= cntInc;
                        if (waitExp) begin
                            res_chan_q    <= chan_q;
                            res_period_q  <= '0;
                            res_timeout_q <= 1'b1;
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phase_scan_ctrl
// Directed bench for phase_scan_ctrl (NCH=8, SETTLE_CYC=4, TIMEOUT_CYC=1000).
// Square-wave generators per channel produce phase pulses with known periods;
// expected results are hand-derived from those periods.
// ---------------------------------------------------------------------------
module tb_phase_scan_ctrl;

    localparam int NCH = 8;

    logic            clk;
    logic            rst;
    logic [NCH-1:0]  phase_in;
    logic [NCH-1:0]  chan_en;
    logic            run;
    logic            res_ready;
    logic            res_valid;
    logic [2:0]      res_chan;
    logic [31:0]     res_period;
    logic            res_timeout;
    logic            busy;

    int cmpCount  = 0;
    int failCount = 0;

    // Generator state: each channel cycles through 4 period entries.
    int             perTab [NCH][4];
    bit [NCH-1:0]   genOn;
    int             gCnt [NCH];
    int             gIdx [NCH];

    phase_scan_ctrl #(
        .NCH        (NCH),
        .SETTLE_CYC (4),
        .TIMEOUT_CYC(1000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .phase_in   (phase_in),
        .chan_en    (chan_en),
        .run        (run),
        .res_ready  (res_ready),
        .res_valid  (res_valid),
        .res_chan   (res_chan),
        .res_period (res_period),
        .res_timeout(res_timeout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Square waves: high for the first half of each period, rising at the
    // start of every period, so edge-to-edge distance equals the table entry.
    always @(negedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (!genOn[ch]) begin
                gCnt[ch]     = 0;
                gIdx[ch]     = 0;
                phase_in[ch] = 1'b0;
            end else begin
                phase_in[ch] = (gCnt[ch] < perTab[ch][gIdx[ch]] / 2);
                if (gCnt[ch] >= perTab[ch][gIdx[ch]] - 1) begin
                    gCnt[ch] = 0;
                    gIdx[ch] = (gIdx[ch] + 1) % 4;
                end else begin
                    gCnt[ch] = gCnt[ch] + 1;
                end
            end
        end
    end

    // Drive the control inputs.
    task automatic applyStimulus(input logic [NCH-1:0] en, input logic runV, input logic rdy);
        chan_en   = en;
        run       = runV;
        res_ready = rdy;
    endtask

    // One counted comparison.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        cmpCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic setPeriod(input int ch, input int p);
        for (int k = 0; k < 4; k++) perTab[ch][k] = p;
    endtask

    // Hold reset for n cycles with all generators stopped.
    task automatic applyReset(input int n);
        rst   = 1'b1;
        genOn = '0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Wait (bounded) for res_valid at a negedge, then check the result fields.
    task automatic expectResult(input string tag, input int ch, input int per,
                                input logic to, input int budget);
        bit got;
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_arrive"}, 32'(got), 32'd1);
        if (got) begin
            checkOutput({tag, "_chan"}, 32'(res_chan), 32'(ch));
            checkOutput({tag, "_period"}, res_period, 32'(per));
            checkOutput({tag, "_timeout"}, 32'(res_timeout), 32'(to));
        end
    endtask

    int          rrChan [4] = '{0, 2, 5, 0};
    int          rrPer  [4] = '{50, 80, 120, 50};
    bit          flagOk;
    logic [2:0]  snapChan;
    logic [31:0] snapPer;
    logic        snapTo;

    initial begin
        genOn = '0;
        for (int ch = 0; ch < NCH; ch++) setPeriod(ch, 100);
        applyStimulus('0, 1'b0, 1'b0);
        rst = 1'b1;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_chan", 32'(res_chan), 32'd0);
        checkOutput("rst_period", res_period, 32'd0);
        checkOutput("rst_timeout", 32'(res_timeout), 32'd0);

        // Single channel, repeated results.
        $display("[TB] single channel");
        applyReset(2);
        setPeriod(0, 100);
        genOn[0] = 1'b1;
        applyStimulus(8'h01, 1'b1, 1'b1);
        expectResult("single0", 0, 100, 1'b0, 1000);
        checkOutput("single_busy", 32'(busy), 32'd1);
        expectResult("single1", 0, 100, 1'b0, 1000);

        // Round-robin order 0,2,5,0.
        $display("[TB] round robin");
        applyReset(2);
        setPeriod(0, 50);
        setPeriod(2, 80);
        setPeriod(5, 120);
        genOn = 8'h25;
        applyStimulus(8'h25, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++)
            expectResult($sformatf("rr%0d", k), rrChan[k], rrPer[k], 1'b0, 2000);

        // Backpressure: hold the next result (channel 2) for 500 cycles.
        $display("[TB] backpressure");
        @(posedge clk);
        #1 res_ready = 1'b0;
        expectResult("bp", 2, 80, 1'b0, 2000);
        snapChan = res_chan;
        snapPer  = res_period;
        snapTo   = res_timeout;
        flagOk   = 1'b1;
        repeat (500) begin
            @(negedge clk);
            if (!res_valid || res_chan !== snapChan || res_period !== snapPer ||
                res_timeout !== snapTo)
                flagOk = 1'b0;
        end
        checkOutput("bp_stable", 32'(flagOk), 32'd1);
        res_ready = 1'b1;
        expectResult("bp_next", 5, 120, 1'b0, 2000);

        // Timeout on a silent channel, twice.
        $display("[TB] timeout");
        applyReset(2);
        applyStimulus(8'h02, 1'b1, 1'b1);
        expectResult("to0", 1, 0, 1'b1, 3000);
        expectResult("to1", 1, 0, 1'b1, 3000);

        // Reset mid-measurement of channel 2 (long period keeps it in MEAS).
        $display("[TB] reset mid-measurement");
        applyReset(2);
        setPeriod(0, 50);
        setPeriod(2, 400);
        genOn[0] = 1'b1;
        applyStimulus(8'h05, 1'b1, 1'b1);
        expectResult("mr_first", 0, 50, 1'b0, 1000);
        genOn[2] = 1'b1;
        repeat (600) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        flagOk = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (res_valid !== 1'b0) flagOk = 1'b0;
        end
        checkOutput("mr_noresult", 32'(flagOk), 32'd1);
        // Stop after this result is accepted.
        run = 1'b0;
        expectResult("mr_after", 0, 50, 1'b0, 1000);
        repeat (5) @(negedge clk);
        checkOutput("stop_busy", 32'(busy), 32'd0);
        checkOutput("stop_valid", 32'(res_valid), 32'd0);

`ifdef PHASE_SCAN_AVG_EN
        // Averaging: any 4 consecutive periods of this pattern sum to 404.
        $display("[TB] averaging");
        applyReset(2);
        perTab[0][0] = 100;
        perTab[0][1] = 102;
        perTab[0][2] = 98;
        perTab[0][3] = 104;
        genOn[0] = 1'b1;
        applyStimulus(8'h01, 1'b1, 1'b1);
        expectResult("avg", 0, 101, 1'b0, 3000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end

endmodule
